// File: rtl/rx_mac.sv
// Ethernet receive MAC: strips preamble/SFD, checks the CRC-32 FCS and forwards
// payload bytes (FCS removed) as an AXI-Stream master with a bad-frame flag on tlast.
module rx_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int MIN_FRAME  = 64,
    parameter int MAX_FRAME  = 1518
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] rgmii_mac_rx_data,
    input  logic                  rgmii_mac_rx_dv,
    input  logic                  rgmii_mac_rx_er,
    output logic [DATA_WIDTH-1:0] m_rx_axis_tdata,
    output logic                  m_rx_axis_tvalid,
    output logic                  m_rx_axis_tlast,
    output logic                  m_rx_axis_tuser
);

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME);
    localparam logic [10:0] CNT_MAX     = 11'd2047;
    localparam logic [10:0] FCS_DEPTH   = 11'd5;

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

    state_t                state_reg, state_next;
    logic                  dv_prev_reg;
    logic [2:0]            pre_cnt_reg, pre_cnt_next;
    logic [10:0]           byte_cnt_reg, byte_cnt_next;
    logic [31:0]           crc_reg, crc_next;
    logic                  er_reg, er_next;
    logic                  shift_en;
    logic [DATA_WIDTH-1:0] dline_reg [0:4];
    logic [DATA_WIDTH-1:0] dline_in  [0:4];
    logic [DATA_WIDTH-1:0] tdata_reg, tdata_next;
    logic                  tvalid_reg, tvalid_next;
    logic                  tlast_reg, tlast_next;
    logic                  tuser_reg, tuser_next;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Delay line: dline_reg[4] is the oldest byte; it holds back the 4 FCS bytes.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_dline
            if (gi == 0) begin : g_head
                assign dline_in[gi] = rgmii_mac_rx_data;
            end else begin : g_tail
                assign dline_in[gi] = dline_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 5; i++) dline_reg[i] <= '0;
        end else if (shift_en) begin
            for (int i = 0; i < 5; i++) dline_reg[i] <= dline_in[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // dv_prev resets high so a frame already in progress at reset release is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dv_prev_reg  <= 1'b1;
            pre_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            crc_reg      <= '1;
            er_reg       <= 1'b0;
            tdata_reg    <= '0;
            tvalid_reg   <= 1'b0;
            tlast_reg    <= 1'b0;
            tuser_reg    <= 1'b0;
        end else begin
            dv_prev_reg  <= rgmii_mac_rx_dv;
            pre_cnt_reg  <= pre_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            crc_reg      <= crc_next;
            er_reg       <= er_next;
            tdata_reg    <= tdata_next;
            tvalid_reg   <= tvalid_next;
            tlast_reg    <= tlast_next;
            tuser_reg    <= tuser_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pre_cnt_next  = pre_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        crc_next      = crc_reg;
        er_next       = er_reg;
        shift_en      = 1'b0;
        tdata_next    = '0;
        tvalid_next   = 1'b0;
        tlast_next    = 1'b0;
        tuser_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rgmii_mac_rx_dv && !dv_prev_reg) begin
                    if (rgmii_mac_rx_data == 8'h55) begin
                        state_next   = PREAMBLE;
                        pre_cnt_next = 3'd1;
                    end else begin
                        state_next = DROP;
                    end
                end else if (rgmii_mac_rx_dv) begin
                    state_next = DROP;
                end
            end
            PREAMBLE: begin
                if (!rgmii_mac_rx_dv || rgmii_mac_rx_er) begin
                    state_next = DROP;
                end else if (rgmii_mac_rx_data == 8'hD5) begin
                    state_next    = PAYLOAD;
                    byte_cnt_next = '0;
                    crc_next      = '1;
                    er_next       = 1'b0;
                end else if (rgmii_mac_rx_data == 8'h55 && pre_cnt_reg != 3'd7) begin
                    pre_cnt_next = pre_cnt_reg + 3'd1;
                end else begin
                    state_next = DROP;
                end
            end
            PAYLOAD: begin
                if (rgmii_mac_rx_dv) begin
                    shift_en = 1'b1;
                    crc_next = crc32_byte(crc_reg, rgmii_mac_rx_data);
                    er_next  = er_reg | rgmii_mac_rx_er;
                    if (byte_cnt_reg != CNT_MAX) byte_cnt_next = byte_cnt_reg + 11'd1;
                    if (byte_cnt_reg >= FCS_DEPTH) begin
                        tvalid_next = 1'b1;
                        tdata_next  = dline_reg[4];
                    end
                end else begin
                    state_next = IDLE;
                    if (byte_cnt_reg >= FCS_DEPTH) begin
                        tvalid_next = 1'b1;
                        tlast_next  = 1'b1;
                        tdata_next  = dline_reg[4];
                        tuser_next  = (crc_reg != CRC_RESIDUE) | er_reg |
                                      (byte_cnt_reg < MIN_LEN) | (byte_cnt_reg > MAX_LEN);
                    end
                end
            end
            DROP: begin
                if (!rgmii_mac_rx_dv) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign m_rx_axis_tdata  = tdata_reg;
    assign m_rx_axis_tvalid = tvalid_reg;
    assign m_rx_axis_tlast  = tlast_reg;
    assign m_rx_axis_tuser  = tuser_reg;

endmodule
